// File: rtl/complex_pair_assembler.sv
// complex_pair_assembler: pairs real/imag component words into {re,im} complex words behind a small FIFO.
module complex_pair_assembler #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_first,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2*DATA_W-1:0]     out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sync_err,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {WAIT_RE, WAIT_IM} state_t;
  state_t r_state, w_state_nx;
  logic [DATA_W-1:0]   r_re;
  logic                r_err;
  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [2*DATA_W-1:0] r_out;
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [LW-1:0]       r_level;
  logic                w_acc, w_pop, w_push, w_load, w_err;
  logic [2*DATA_W-1:0] w_pair, w_head_nx;
  logic [AW-1:0]       w_rptr_nx;
  logic [LW-1:0]       w_level_nx, w_left;
  assign in_ready  = r_level != LW'(DEPTH);
  assign out_valid = r_level != '0;
  assign out_data  = r_out;
  assign sync_err  = r_err;
  assign level     = r_level;
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_pair    = {r_re, in_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= WAIT_RE;
    else        r_state <= w_state_nx;
  always_comb begin
    w_state_nx = r_state;
    if (w_acc) w_state_nx = in_first ? WAIT_IM : WAIT_RE;
  end
  always_comb begin
    w_push = w_acc && r_state == WAIT_IM && !in_first;
    w_load = w_acc && in_first;
    w_err  = w_acc && (r_state == WAIT_RE ? !in_first : in_first);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_re  <= '0;
      r_err <= 1'b0;
    end else begin
      r_re  <= w_load ? in_data : r_re;
      r_err <= w_err;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= w_pair;
  // the output register preloads the next head; a word pushed into a draining FIFO bypasses memory
  always_comb begin
    w_rptr_nx  = r_rptr + AW'(w_pop);
    w_left     = r_level - LW'(w_pop);
    w_level_nx = w_left + LW'(w_push);
    w_head_nx  = w_level_nx == '0 ? r_out : (w_left == '0 ? w_pair : r_mem[w_rptr_nx]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_out   <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= w_rptr_nx;
      r_level <= w_level_nx;
      r_out   <= w_head_nx;
    end
endmodule

// File: doc/complex_pair_assembler.md
Name: complex_pair_assembler

Overview:
- Input-side counterpart of the 64-bit complex datapath.
- Receives single-precision IEEE-754 words on a 32-bit valid/ready stream, real part first and imaginary part second.
- Assembles each pair into one 64-bit complex word {real[63:32], imag[31:0]} and buffers it in a small output FIFO.
- Feeds complex operators such as the conjugate, adder and multiplier pipelines, which consume the {re,im} packing.

Parameters:
- DATA_W, 32: width of one real or imaginary component; output width is 2*DATA_W.
- DEPTH, 2: output FIFO depth in complex words; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  component word, bit-exact float
- in_first  input  1  1 = word is a real part (start of pair); 0 = imaginary part
- in_valid  input  1  in_data/in_first valid
- in_ready  output  1  block can accept a word this cycle
- out_data  output  2*DATA_W  {real, imag} at FIFO head
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- sync_err  output  1  one-cycle pulse on a pairing violation
- level  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately, including mid-pair. Reset values:
  - state = WAIT_RE; re_reg = 0
  - FIFO empty, level = 0, out_valid = 0, out_data = 0
  - sync_err = 0
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output pop = out_valid && out_ready.
- in_ready = (level != DEPTH) in both states. It is combinational from level only and never depends on in_valid.
- FSM state WAIT_RE, on accept:
  - in_first = 1: re_reg <= in_data; go to WAIT_IM.
  - in_first = 0: word dropped; sync_err = 1 next cycle; stay in WAIT_RE.
- FSM state WAIT_IM, on accept:
  - in_first = 0: push {re_reg, in_data}; go to WAIT_RE.
  - in_first = 1: resync. re_reg <= in_data; sync_err = 1 next cycle; stay in WAIT_IM. The old real part is discarded.
- No accept means no state change.
- Latency: imaginary word accepted at edge N with FIFO empty gives out_valid = 1 and out_data = pair after edge N. Visible in cycle N+1.
- FIFO:
  - Registered output; out_data always shows the head entry; head is stable while out_valid && !out_ready.
  - Push and pop in the same cycle: level unchanged, order preserved, no bubble.
  - Full (level = DEPTH): in_ready = 0. A pop that cycle does not allow a same-cycle push; in_ready rises the next cycle.
  - Empty: out_valid = 0; out_data holds the last popped value; pop ignored.
  - Read and write pointers wrap modulo DEPTH.
- Data is passed bit-exact with no float interpretation; NaN and denormal values are untouched.
- sync_err is registered, one cycle per violation, and asserts on consecutive cycles for back-to-back violations.

Test Plan:
- Basic pair:
  - Stimulus: reset; send 3F800000 (first=1), then 40000000 (first=0); out_ready = 1.
  - Required: out_valid one cycle after the second accept; out_data = 3F800000_40000000; level returns to 0.
- Backpressure/full, DEPTH=2:
  - Stimulus: out_ready = 0; send 3 pairs (1.0,2.0), (3.0,-1.0), (0.5,0.25).
  - Required: level = 2 and in_ready = 0 after pair 2; the real part of pair 3 is not accepted.
  - Stimulus: raise out_ready.
  - Required: outputs 3F800000_40000000, 40400000_BF800000, 3F000000_3E800000 in order.
- Missing real part:
  - Stimulus: in WAIT_RE send 40000000 with first=0.
  - Required: sync_err pulses one cycle; no output; the next valid pair is assembled correctly.
- Missing imaginary part:
  - Stimulus: send 3F800000 (first=1), 40400000 (first=1), BF800000 (first=0).
  - Required: one sync_err pulse; a single output 40400000_BF800000.
- Streaming:
  - Stimulus: in_valid = 1 and out_ready = 1 continuously for 20 pairs.
  - Required: one output every 2 cycles, no loss, level <= 1.
- Reset mid-operation:
  - Stimulus: assert rst_n low after a real part with 1 entry queued.
  - Required: out_valid = 0, level = 0, state WAIT_RE immediately; a following imaginary word (first=0) produces sync_err, not output.
